// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit with a single-outstanding bus port.
// Checks alignment, issues the bus transaction and extends load data.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] result_i,
  input  logic [31:0] except_type_i,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_req,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] except_type_o,
  output logic [31:0] bad_vaddr_o
);

  localparam logic [7:0] LB_OP  = 8'b1110_0000;
  localparam logic [7:0] LBU_OP = 8'b1110_0100;
  localparam logic [7:0] LH_OP  = 8'b1110_0001;
  localparam logic [7:0] LHU_OP = 8'b1110_0101;
  localparam logic [7:0] LW_OP  = 8'b1110_0011;
  localparam logic [7:0] SB_OP  = 8'b1110_1000;
  localparam logic [7:0] SH_OP  = 8'b1110_1001;
  localparam logic [7:0] SW_OP  = 8'b1110_1011;

  localparam logic [31:0] ADEL = 32'h0000_0010;
  localparam logic [31:0] ADES = 32'h0000_0020;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_op;
  logic [1:0]  r_lo;
  logic        r_flush;

  logic        w_load;
  logic        w_store;
  logic        w_byte;
  logic        w_half;
  logic        w_mem;
  logic        w_mis;
  logic        w_access;
  logic [3:0]  w_be;
  logic [31:0] w_st_data;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_ld_data;
  logic        w_r_load;

  // Opcode decode: access class and size
  always_comb begin
    w_load  = 1'b0;
    w_store = 1'b0;
    w_byte  = 1'b0;
    w_half  = 1'b0;
    unique case (op_i)
      LB_OP, LBU_OP: begin w_load = 1'b1; w_byte = 1'b1; end
      LH_OP, LHU_OP: begin w_load = 1'b1; w_half = 1'b1; end
      LW_OP:         w_load = 1'b1;
      SB_OP:         begin w_store = 1'b1; w_byte = 1'b1; end
      SH_OP:         begin w_store = 1'b1; w_half = 1'b1; end
      SW_OP:         w_store = 1'b1;
      default:       ;
    endcase
  end

  assign w_mem = w_load | w_store;

  // Alignment check, byte enables and replicated store data
  always_comb begin
    w_mis     = 1'b0;
    w_be      = 4'b1111;
    w_st_data = wdata_i;
    unique case (1'b1)
      w_byte: begin
        w_be      = 4'b0001 << addr_i[1:0];
        w_st_data = {4{wdata_i[7:0]}};
      end
      w_half: begin
        w_mis     = addr_i[0];
        w_be      = addr_i[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{wdata_i[15:0]}};
      end
      default: w_mis = w_mem & (addr_i[1:0] != 2'b00);
    endcase
  end

  assign w_access = w_mem & (except_type_i == 32'd0) & ~w_mis & ~flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_access) w_next = REQ;
      REQ: begin
        if (bus_ack) w_next = (r_flush | flush) ? IDLE : DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus request registers, captured read data and flush memory
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_op        <= 8'd0;
      r_lo        <= 2'd0;
      r_flush     <= 1'b0;
    end else begin
      if (r_state == IDLE && w_access) begin
        r_bus_we    <= w_store;
        r_bus_addr  <= {addr_i[31:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_st_data;
        r_op        <= op_i;
        r_lo        <= addr_i[1:0];
        r_flush     <= 1'b0;
      end
      if (r_state == REQ) begin
        if (flush)   r_flush <= 1'b1;
        if (bus_ack) r_rdata <= bus_rdata;
      end
    end
  end

  assign w_rbyte = r_rdata[{r_lo, 3'b000} +: 8];
  assign w_rhalf = r_lo[1] ? r_rdata[31:16] : r_rdata[15:0];

  // Load data extension for the captured word
  always_comb begin
    w_ld_data = r_rdata;
    w_r_load  = 1'b1;
    unique case (r_op)
      LB_OP:   w_ld_data = {{24{w_rbyte[7]}}, w_rbyte};
      LBU_OP:  w_ld_data = {24'd0, w_rbyte};
      LH_OP:   w_ld_data = {{16{w_rhalf[15]}}, w_rhalf};
      LHU_OP:  w_ld_data = {16'd0, w_rhalf};
      LW_OP:   w_ld_data = r_rdata;
      default: w_r_load  = 1'b0;
    endcase
  end

  assign bus_req   = (r_state == REQ);
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

  // Writeback, exception and stall outputs per state
  always_comb begin
    wd_o          = wd_i;
    wreg_o        = wreg_i;
    wdata_o       = result_i;
    except_type_o = except_type_i;
    bad_vaddr_o   = 32'd0;
    stall_req     = 1'b0;
    if (rst) begin
      wreg_o        = 1'b0;
      wdata_o       = 32'd0;
      except_type_o = 32'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (flush) begin
            wreg_o        = 1'b0;
            except_type_o = 32'd0;
          end else if (w_mem) begin
            wreg_o = 1'b0;
            if (except_type_i == 32'd0) begin
              if (w_mis) begin
                except_type_o = except_type_i | (w_load ? ADEL : ADES);
                bad_vaddr_o   = addr_i;
              end else begin
                stall_req = 1'b1;
              end
            end
          end
        end
        REQ: begin
          stall_req = 1'b1;
          wreg_o    = 1'b0;
        end
        DONE: begin
          if (w_r_load) wdata_o = w_ld_data;
          if (flush)    wreg_o  = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed checks of mem_access bus timing,
// alignment faults, data lanes, flush and reset behaviour.
module tb_mem_access;

  localparam logic [7:0] LB_OP  = 8'b1110_0000;
  localparam logic [7:0] LBU_OP = 8'b1110_0100;
  localparam logic [7:0] LH_OP  = 8'b1110_0001;
  localparam logic [7:0] LHU_OP = 8'b1110_0101;
  localparam logic [7:0] LW_OP  = 8'b1110_0011;
  localparam logic [7:0] SB_OP  = 8'b1110_1000;
  localparam logic [7:0] SH_OP  = 8'b1110_1001;
  localparam logic [7:0] SW_OP  = 8'b1110_1011;
  localparam logic [7:0] NOP_OP = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [7:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] result_i;
  logic [31:0] except_type_i;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall_req;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] except_type_o;
  logic [31:0] bad_vaddr_o;

  int total = 0;
  int bad   = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .flush(flush),
    .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .result_i(result_i),
    .except_type_i(except_type_i),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_req(stall_req), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .except_type_o(except_type_o),
    .bad_vaddr_o(bad_vaddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one access from IDLE, acking after dly REQ cycles.
  task automatic txn(input logic [7:0] op, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int dly, output int st,
                     output logic [31:0] wb, output logic stable,
                     output logic [3:0] be, output logic [31:0] ba,
                     output logic [31:0] bw, output logic we);
    int w;
    logic seen;
    logic fin;
    op_i = op; addr_i = a; wdata_i = wd;
    wreg_i = 1'b1; wd_i = 5'd7; result_i = 32'h5555_AAAA;
    st = 0; w = 0; seen = 1'b0; fin = 1'b0; stable = 1'b1;
    wb = 32'hx; be = 4'hx; ba = 32'hx; bw = 32'hx; we = 1'bx;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (!stall_req) begin
        wb = wdata_o;
        fin = 1'b1;
        break;
      end
      st++;
      if (bus_req) begin
        if (!seen) begin
          seen = 1'b1;
          be = bus_be; ba = bus_addr; bw = bus_wdata; we = bus_we;
        end else if (bus_be !== be || bus_addr !== ba ||
                     bus_wdata !== bw || bus_we !== we) begin
          stable = 1'b0;
        end
        bus_ack = (w == dly);
        bus_rdata = rd;
        w++;
      end
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
    end
    chk("txn_finish", {31'd0, fin}, 32'd1);
    op_i = NOP_OP;
    step();
  endtask

  int          st;
  logic [31:0] wb;
  logic        stable;
  logic [3:0]  be;
  logic [31:0] ba;
  logic [31:0] bw;
  logic        we;

  initial begin
    rst = 1'b1; flush = 1'b0; op_i = LW_OP; addr_i = 32'h40;
    wdata_i = 32'h0; wd_i = 5'd3; wreg_i = 1'b1;
    result_i = 32'h1234_5678; except_type_i = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    step();
    step();
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    rst = 1'b0; op_i = NOP_OP;
    #2;
    chk("pass_wdata", wdata_o, 32'h1234_5678);
    chk("pass_wreg", {31'd0, wreg_o}, 32'd1);
    chk("pass_wd", {27'd0, wd_o}, 32'd3);
    step();

    txn(LB_OP, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0,
        st, wb, stable, be, ba, bw, we);
    chk("lb_be", {28'd0, be}, 32'b1000);
    chk("lb_addr", ba, 32'h8000_0000);
    chk("lb_stall", st, 2);
    chk("lb_data", wb, 32'hFFFF_FF80);

    txn(SH_OP, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 0,
        st, wb, stable, be, ba, bw, we);
    chk("sh_we", {31'd0, we}, 32'd1);
    chk("sh_addr", ba, 32'h0000_0100);
    chk("sh_be", {28'd0, be}, 32'b1100);
    chk("sh_wdata", bw, 32'hABCD_ABCD);

    txn(LHU_OP, 32'h0000_0010, 32'h0, 32'h1234_F00D, 3,
        st, wb, stable, be, ba, bw, we);
    chk("lhu_stable", {31'd0, stable}, 32'd1);
    chk("lhu_stall", st, 5);
    chk("lhu_be", {28'd0, be}, 32'b0011);
    chk("lhu_data", wb, 32'h0000_F00D);

    txn(LH_OP, 32'h0000_0022, 32'h0, 32'h8001_0000, 1,
        st, wb, stable, be, ba, bw, we);
    chk("lh_data", wb, 32'hFFFF_8001);
    chk("lh_stall", st, 3);

    txn(LBU_OP, 32'h0000_0031, 32'h0, 32'h0000_A500, 0,
        st, wb, stable, be, ba, bw, we);
    chk("lbu_be", {28'd0, be}, 32'b0010);
    chk("lbu_data", wb, 32'h0000_00A5);

    txn(SB_OP, 32'h0000_0042, 32'h0000_00C3, 32'h0, 0,
        st, wb, stable, be, ba, bw, we);
    chk("sb_be", {28'd0, be}, 32'b0100);
    chk("sb_wdata", bw, 32'hC3C3_C3C3);

    txn(SW_OP, 32'h0000_0048, 32'hDEAD_BEEF, 32'h0, 0,
        st, wb, stable, be, ba, bw, we);
    chk("sw_be", {28'd0, be}, 32'hF);
    chk("sw_wdata", bw, 32'hDEAD_BEEF);

    txn(LW_OP, 32'h0000_0050, 32'h0, 32'hCAFE_0001, 0,
        st, wb, stable, be, ba, bw, we);
    chk("lw_data", wb, 32'hCAFE_0001);

    op_i = LW_OP; addr_i = 32'h0000_0006; wreg_i = 1'b1;
    #2;
    chk("adel_exc", except_type_o, 32'h10);
    chk("adel_bad", bad_vaddr_o, 32'h6);
    chk("adel_wreg", {31'd0, wreg_o}, 32'd0);
    chk("adel_stall", {31'd0, stall_req}, 32'd0);
    step();
    chk("adel_noreq", {31'd0, bus_req}, 32'd0);

    op_i = SH_OP; addr_i = 32'h0000_0103; except_type_i = 32'h100;
    #2;
    chk("ades_exc_in", except_type_o, 32'h100);
    chk("exc_in_bad", bad_vaddr_o, 32'h0);
    chk("exc_in_stall", {31'd0, stall_req}, 32'd0);
    except_type_i = 32'h0;
    #1;
    chk("ades_exc", except_type_o, 32'h20);
    chk("ades_bad", bad_vaddr_o, 32'h103);

    op_i = SW_OP; addr_i = 32'h60; flush = 1'b1;
    #2;
    chk("flidle_stall", {31'd0, stall_req}, 32'd0);
    chk("flidle_wreg", {31'd0, wreg_o}, 32'd0);
    step();
    chk("flidle_noreq", {31'd0, bus_req}, 32'd0);
    flush = 1'b0;

    op_i = LW_OP; addr_i = 32'h70; wreg_i = 1'b1;
    bus_rdata = 32'h7777_7777;
    step();
    flush = 1'b1;
    #2;
    chk("flreq_req1", {31'd0, bus_req}, 32'd1);
    chk("flreq_wreg1", {31'd0, wreg_o}, 32'd0);
    step();
    flush = 1'b0;
    step();
    bus_ack = 1'b1;
    #2;
    chk("flreq_req3", {31'd0, bus_req}, 32'd1);
    chk("flreq_stall3", {31'd0, stall_req}, 32'd1);
    step();
    bus_ack = 1'b0; op_i = NOP_OP; result_i = 32'h0000_0055;
    #2;
    chk("flreq_idle_req", {31'd0, bus_req}, 32'd0);
    chk("flreq_nodone", wdata_o, 32'h0000_0055);
    step();

    op_i = LW_OP; addr_i = 32'h80;
    step();
    chk("rstreq_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    #2;
    chk("rstreq_stall", {31'd0, stall_req}, 32'd0);
    step();
    rst = 1'b0; op_i = NOP_OP;
    #2;
    chk("rstreq_drop", {31'd0, bus_req}, 32'd0);
    chk("rstreq_idle", {31'd0, stall_req}, 32'd0);
    chk("rstreq_be", {28'd0, bus_be}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high; clock clk.
REQ-003 SHALL: flush  input  1  pipeline flush from exception/control logic.
REQ-004 SHALL: op_i  input  8  memory opcode: EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP per define.vh; any other code = non-memory.
REQ-005 SHALL: addr_i  input  32  effective address; wdata_i  input  32  store data (rt).
REQ-006 SHALL: wd_i  input  5, wreg_i  input  1, result_i  input  32  destination reg, write enable, ALU result.
REQ-007 SHALL: except_type_i  input  32  exception flags accumulated upstream.
REQ-008 SHALL: bus_req  output  1; bus_we  output  1; bus_addr  output  32; bus_be  output  4; bus_wdata  output  32.
REQ-009 SHALL: bus_ack  input  1  one-cycle completion strobe; bus_rdata  input  32  valid when bus_ack=1.
REQ-010 SHALL: stall_req  output  1  hold all upstream stages, including the EX/MEM register, while 1.
REQ-011 SHALL: wd_o  output  5; wreg_o  output  1; wdata_o  output  32  writeback to MEM/WB register.
REQ-012 SHALL: except_type_o  output  32; bad_vaddr_o  output  32  faulting address.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-014 SHALL define "access" as: memory op, except_type_i==0, aligned, flush=0.
REQ-015 SHALL define misaligned as: LH/LHU/SH with addr_i[0]=1; LW/SW with addr_i[1:0]!=0; byte ops never misaligned.
REQ-016 IDLE, non-memory op: wd_o=wd_i, wreg_o=wreg_i, wdata_o=result_i, except_type_o=except_type_i, stall_req=0; zero-latency pass-through.
REQ-017 IDLE, misaligned load: except_type_o=except_type_i|bit4 (AdEL), wreg_o=0, bad_vaddr_o=addr_i, no bus access, no stall.
REQ-018 IDLE, misaligned store: except_type_o=except_type_i|bit5 (AdES), bad_vaddr_o=addr_i, no bus access, no stall.
REQ-019 Memory op with except_type_i!=0: no bus access, no stall, wreg_o=0, except_type_o=except_type_i.
REQ-020 IDLE with access: stall_req=1 combinationally; register bus_addr={addr_i[31:2],2'b00}, bus_we, bus_be, bus_wdata; next state REQ.
REQ-021 REQ: bus_req=1, stall_req=1; bus outputs stable until bus_ack sampled 1; on ack capture bus_rdata, next state DONE.
REQ-022 DONE: stall_req=0, bus_req=0; wdata_o=extended captured data for loads; wd_o=wd_i, wreg_o=wreg_i; next state IDLE.
REQ-023 Byte enables (little-endian): byte ops be=4'b0001<<addr[1:0]; half ops be=addr[1]?4'b1100:4'b0011; word ops be=4'b1111; loads use same be.
REQ-024 Store data: SB {4{wdata_i[7:0]}}, SH {2{wdata_i[15:0]}}, SW wdata_i.
REQ-025 Load extract: lane selected by addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-026 bad_vaddr_o SHALL be 0 when no address exception is raised.
REQ-027 Flush in IDLE: no access started; outputs wreg_o=0, except_type_o=0.
REQ-028 Flush in REQ: bus_req held until bus_ack (transaction never aborted); on ack go IDLE, skip DONE, wreg_o=0 throughout; stall_req stays 1 until ack.
REQ-029 Flush in DONE: wreg_o=0; next state IDLE.
REQ-030 Minimum load/store latency: 3 cycles (IDLE, REQ with immediate ack, DONE); each extra ack wait adds one cycle.

Reset
REQ-031 rst SHALL force state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, captured data=0 on the next edge.
REQ-032 rst during REQ SHALL drop bus_req next cycle; outstanding transaction is discarded.
REQ-033 During rst, combinational outputs SHALL be stall_req=0, wreg_o=0, wdata_o=0, except_type_o=0, bad_vaddr_o=0.

Verification
REQ-034 LB addr=0x80000003, bus_rdata=0x80FF1234, ack on first REQ cycle -> bus_be=4'b1000, stall 2 cycles, DONE wdata_o=0xFFFFFF80.
REQ-035 SH addr=0x00000102, wdata_i=0x0000ABCD -> bus_we=1, bus_addr=0x00000100, bus_be=4'b1100, bus_wdata=0xABCDABCD.
REQ-036 LW addr=0x00000006 -> no bus_req, except_type_o bit4=1, bad_vaddr_o=0x00000006, wreg_o=0, stall_req=0.
REQ-037 LHU addr=0x10, ack delayed 3 cycles, bus_rdata=0x1234F00D -> bus outputs stable across wait, stall 5 cycles, wdata_o=0x0000F00D.
REQ-038 Flush asserted first REQ cycle, ack 2 cycles later -> bus_req held until ack, no DONE, wreg_o=0, IDLE after ack.
REQ-039 rst asserted in REQ -> bus_req=0 next cycle, state IDLE, stall_req=0.
